ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader.sv | 159 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Serialises a valid/ready stream of bitstream words into one tile's ccff chain.
// Optional readback parity check is compiled in with CCFF_CHAIN_LOADER_VERIFY_EN.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);

    localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
        VERIFY,
`endif
        DONE
    } state_t;

    state_t            state_q;
    logic              cfg_ready_q;
    logic              prog_en_q;
    logic              head_q;
    logic              busy_q;
    logic              done_q;
    logic [WORD_W-1:0] sreg_q;
    logic [WB_W-1:0]   word_bit_q;
    logic [CNT_W-1:0]  bit_cnt_q;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    logic              load_par_q;
    logic              rb_par_q;
    logic              verr_q;
`endif

    // head_q always holds the bit being driven this cycle; sreg_q holds the
    // not-yet-driven remainder of the current word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b0;
            prog_en_q   <= 1'b0;
            head_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sreg_q      <= '0;
            word_bit_q  <= '0;
            bit_cnt_q   <= '0;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
            load_par_q  <= 1'b0;
            rb_par_q    <= 1'b0;
            verr_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= FETCH;
                        cfg_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        bit_cnt_q   <= '0;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
                        load_par_q  <= 1'b0;
                        rb_par_q    <= 1'b0;
                        verr_q      <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        state_q     <= SHIFT;
                        cfg_ready_q <= 1'b0;
                        prog_en_q   <= 1'b1;
                        head_q      <= cfg_word[0];
                        sreg_q      <= cfg_word >> 1;
                        word_bit_q  <= '0;
                    end
                end
                SHIFT: begin
                    bit_cnt_q  <= bit_cnt_q + 1'b1;
                    word_bit_q <= word_bit_q + 1'b1;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
                    load_par_q <= load_par_q ^ head_q;
`endif
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
                        state_q   <= VERIFY;
                        bit_cnt_q <= '0;
                        head_q    <= ccff_tail;
                        rb_par_q  <= 1'b0;
`else
                        state_q   <= DONE;
                        prog_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
`endif
                    end else if (word_bit_q == LAST_WBIT) begin
                        state_q     <= FETCH;
                        prog_en_q   <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end else begin
                        head_q <= sreg_q[0];
                        sreg_q <= sreg_q >> 1;
                    end
                end
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
                // The tail is fed back through head_q, so the head lags the tail by
                // one cycle; every original chain bit still reaches the tail exactly once.
                VERIFY: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    head_q    <= ccff_tail;
                    rb_par_q  <= rb_par_q ^ ccff_tail;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q   <= DONE;
                        prog_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        verr_q    <= (rb_par_q ^ ccff_tail) != load_par_q;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign prog_en   = prog_en_q;
    assign ccff_head = head_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    assign verify_err = verr_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader: words, FETCH stalls and stray start
// pulses are checked against a bit-stream model and a behavioural chain.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 16;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [WORD_W-1:0] cfg_word = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              prog_en;
    logic              busy;
    logic              done;
    logic              verify_err;

    int checkCount = 0;
    int failCount  = 0;

    int   cyc = 0;
    int   shiftTotal = 0;
    int   hsTotal = 0;
    int   lastShiftCyc = 0;
    int   doneRiseCyc = 0;
    logic prevDone = 1'b0;
    bit   headLog[$];
    logic [CHAIN_LEN-1:0] chainM = '0;

    logic [WORD_W-1:0]    words[NWORDS];
    int                   gaps[NWORDS];
    logic [CHAIN_LEN-1:0] lastHeadVec;

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_word  (cfg_word),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .prog_en   (prog_en),
        .busy      (busy),
        .done      (done),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    assign ccff_tail = chainM[CHAIN_LEN-1];

    // Observes the chain interface mid-cycle: shift pulses, handshakes and done edges.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (prog_en === 1'b1) begin
            shiftTotal   <= shiftTotal + 1;
            lastShiftCyc <= cyc;
            headLog.push_back(ccff_head);
            chainM       <= {chainM[CHAIN_LEN-2:0], ccff_head};
        end
        if (cfg_valid === 1'b1 && cfg_ready === 1'b1) hsTotal <= hsTotal + 1;
        if (done === 1'b1 && !prevDone) doneRiseCyc <= cyc;
        prevDone <= (done === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One full load from IDLE or DONE using words[] and gaps[] (stall cycles in FETCH).
    task automatic applyStimulus(input bit pokeStart);
        int baseShift, baseHs, baseLog, n, stallBad;
        logic [CHAIN_LEN-1:0] expVec, gotVec, expChain;
        stallBad  = 0;
        baseShift = shiftTotal;
        baseHs    = hsTotal;
        baseLog   = headLog.size();
        pulseStart();
        checkOutput("startDoneLow", done, 0);
        checkOutput("startReady", cfg_ready, 1);
        for (int w = 0; w < NWORDS; w++) begin
            n = 0;
            while (cfg_ready !== 1'b1 && n < 200) begin
                @(posedge clk); #1; n++;
            end
            checkOutput("readyWait", cfg_ready, 1);
            for (int g = 0; g < gaps[w]; g++) begin
                if (!(cfg_ready === 1'b1 && prog_en === 1'b0)) stallBad++;
                @(posedge clk); #1;
            end
            cfg_valid = 1'b1;
            cfg_word  = words[w];
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            cfg_word  = WORD_W'($urandom);
            if (pokeStart && w == 0) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("doneSeen", done, 1);
        @(negedge clk); #1;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            expVec[i]                = words[i / WORD_W][i % WORD_W];
            expChain[CHAIN_LEN-1-i]  = expVec[i];
            gotVec[i]                = (baseLog + i < headLog.size()) ? headLog[baseLog + i] : 1'bx;
        end
        lastHeadVec = gotVec;
        checkOutput("shiftCount", shiftTotal - baseShift, CHAIN_LEN);
        checkOutput("headSeq", gotVec, expVec);
        checkOutput("chainContents", chainM, expChain);
        checkOutput("doneLatency", doneRiseCyc - lastShiftCyc, 1);
        checkOutput("stallOutputs", stallBad, 0);
        checkOutput("doneBusy", busy, 0);
        checkOutput("doneProgEn", prog_en, 0);
        checkOutput("doneVerifyErr", verify_err, 0);
        // Words offered while DONE must not be taken.
        @(posedge clk); #1 cfg_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk); #1;
        checkOutput("handshakes", hsTotal - baseHs, NWORDS);
        checkOutput("doneHeld", done, 1);
        checkOutput("doneReady", cfg_ready, 0);
    endtask

    // Reset during the 10th shift cycle of a load.
    task automatic resetMidLoad();
        int baseShift, n;
        baseShift = shiftTotal;
        pulseStart();
        cfg_valid = 1'b1;
        cfg_word  = WORD_W'($urandom);
        n = 0;
        while (shiftTotal - baseShift < 10 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("midShiftReached", shiftTotal - baseShift, 10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("rstProgEn", prog_en, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstReady", cfg_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idleStays", {busy, prog_en, cfg_ready}, 3'b000);
        checkOutput("rstShiftTotal", shiftTotal - baseShift, 10);
    endtask

    task automatic setFixedWords(input int gap1);
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'h0F;
        gaps[0]  = 0;
        gaps[1]  = gap1;
        gaps[2]  = 0;
    endtask

    initial begin
        $display("[TB] starting ccff_chain_loader bench");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetReady", cfg_ready, 0);
        checkOutput("resetProgEn", prog_en, 0);
        checkOutput("resetHead", ccff_head, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetVerifyErr", verify_err, 0);
        reset = 1'b0;

        setFixedWords(0);
        applyStimulus(1'b0);
        checkOutput("headFixed", lastHeadVec, 20'hF3CA5);

        setFixedWords(5);
        applyStimulus(1'b0);
        checkOutput("headFixedStall", lastHeadVec, 20'hF3CA5);

        setFixedWords(0);
        applyStimulus(1'b1);

        resetMidLoad();
        setFixedWords(2);
        applyStimulus(1'b0);
        checkOutput("headAfterReset", lastHeadVec, 20'hF3CA5);

        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < NWORDS; w++) begin
                words[w] = WORD_W'($urandom);
                gaps[w]  = int'($urandom_range(0, 3));
            end
            applyStimulus(bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
